// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the registered ripple adder and its consumers.
//
//   ADDER_MAX_WIDTH  widest operand the adder is built for
//   adder_result_t   {co, so} result bundle, sized for the widest adder;
//                    narrower adders zero-extend so into it
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_MAX_WIDTH = 64;

    typedef struct packed {
        logic                       co;
        logic [ADDER_MAX_WIDTH-1:0] so;
    } adder_result_t;

endpackage : adder_pkg

// File: rtl/half_adder.sv
// ----------------------------------------------------------------------------
// half_adder
//   One-bit half adder, purely combinational. Two of these plus an OR gate
//   form one full-adder cell of the ripple chain in full_adder.
//
//   Ports
//     a  in   operand bit
//     b  in   operand bit
//     s  out  sum bit,   a ^ b
//     c  out  carry bit, a & b
// ----------------------------------------------------------------------------
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : half_adder

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//   Registered WIDTH-bit unsigned adder: {co, so} = a + b + c, one cycle of
//   latency, one new operand set accepted every clock. The combinational
//   path is a structural ripple chain of full-adder cells, each built from two
//   half_adder instances and an OR gate. Only so, co and out_valid are
//   registered.
//
//   Parameters
//     WIDTH      operand/sum width, 1..ADDER_MAX_WIDTH
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   synchronous, active-high reset
//     in_valid   in   a/b/c sampled on this edge when high
//     a          in   operand A, WIDTH bits
//     b          in   operand B, WIDTH bits
//     c          in   carry in
//     so         out  registered sum, (a+b+c) mod 2^WIDTH
//     co         out  registered carry out, bit WIDTH of a+b+c
//     out_valid  out  high for one cycle per new result
// ----------------------------------------------------------------------------
module full_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] so,
    output logic             co,
    output logic             out_valid
);

    generate
        if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
            $error("full_adder: WIDTH out of range 1..64");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Ripple chain. carry[i] is the carry into bit i; carry[WIDTH] is co.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = c;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            logic p;   // propagate: a ^ b
            logic g;   // generate:  a & b
            logic t;   // carry passed through by the propagate term

            half_adder u_ha_ab (
                .a (a[i]),
                .b (b[i]),
                .s (p),
                .c (g)
            );

            half_adder u_ha_pc (
                .a (p),
                .b (carry[i]),
                .s (sum[i]),
                .c (t)
            );

            assign carry[i+1] = g | t;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register stage. The adder result is only loaded when in_valid
    // is high, so anything on a/b/c while idle (including X) never reaches
    // so/co; they simply hold.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] so_d, so_q;
    logic             co_d, co_q;
    logic             valid_d, valid_q;

    always_comb begin
        so_d    = so_q;
        co_d    = co_q;
        valid_d = 1'b0;
        if (in_valid) begin
            so_d    = sum;
            co_d    = carry[WIDTH];
            valid_d = 1'b1;
        end
    end

    // Reset has priority over a simultaneous operand set, which is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            so_q    <= '0;
            co_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            so_q    <= so_d;
            co_q    <= co_d;
            valid_q <= valid_d;
        end
    end

    assign so        = so_q;
    assign co        = co_q;
    assign out_valid = valid_q;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// ----------------------------------------------------------------------------
// tb_full_adder
//   Scoreboard bench for full_adder: a WIDTH=1 and a WIDTH=8 instance share
//   clock and reset. Stimulus pushes hand-computed expected results (with the
//   cycle they are due) into per-instance queues; monitors pop and compare
//   whenever out_valid is seen.
// ----------------------------------------------------------------------------
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       v1, a1, b1, c1;
    logic       so1, co1, ov1;

    logic       v8, c8;
    logic [7:0] a8, b8;
    logic [7:0] so8;
    logic       co8, ov8;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .so        (so1),
        .co        (co1),
        .out_valid (ov1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .c         (c8),
        .so        (so8),
        .co        (co8),
        .out_valid (ov8)
    );

    typedef struct {
        logic [7:0] so;
        logic       co;
        int         cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    // Monitors: results must arrive exactly in their due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (ov1) begin
            if (q1.size() == 0) begin
                chk("w1 unexpected out_valid", ov1, 1'b0);
            end else begin
                e = q1.pop_front();
                chk("w1 so", so1, e.so);
                chk("w1 co", co1, e.co);
                chk("w1 latency", cyc, e.cyc);
            end
        end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
            chk("w1 missing out_valid", ov1, 1'b1);
            void'(q1.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov8) begin
            if (q8.size() == 0) begin
                chk("w8 unexpected out_valid", ov8, 1'b0);
            end else begin
                e = q8.pop_front();
                chk("w8 so", so8, e.so);
                chk("w8 co", co8, e.co);
                chk("w8 latency", cyc, e.cyc);
            end
        end else if (q8.size() > 0 && q8[0].cyc <= cyc) begin
            chk("w8 missing out_valid", ov8, 1'b1);
            void'(q8.pop_front());
        end
    end

    // Called at a negedge: drive one operand set, record its expected result.
    task automatic op1(input logic a, input logic b, input logic c,
                       input logic so_e, input logic co_e);
        exp_t e;
        a1 = a; b1 = b; c1 = c; v1 = 1'b1;
        e.so = {7'b0, so_e}; e.co = co_e; e.cyc = cyc + 1;
        q1.push_back(e);
        @(negedge clk);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] so_e, input logic co_e);
        exp_t e;
        a8 = a; b8 = b; c8 = c; v8 = 1'b1;
        e.so = so_e; e.co = co_e; e.cyc = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Truth table of the 1-bit full adder, indexed by {a,b,c}.
        logic [7:0] so_tab;
        logic [7:0] co_tab;
        logic [2:0] abc;
        // Half-adder path (c=0), indexed by {a,b}.
        logic [3:0] ha_so;
        logic [3:0] ha_co;
        logic [1:0] ab;
        so_tab = 8'h96;
        co_tab = 8'hE8;
        ha_so  = 4'b0110;
        ha_co  = 4'b1000;

        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset w1 so", so1, 1'b0);
        chk("reset w1 co", co1, 1'b0);
        chk("reset w1 out_valid", ov1, 1'b0);
        chk("reset w8 so", so8, 8'h00);
        chk("reset w8 co", co8, 1'b0);
        chk("reset w8 out_valid", ov8, 1'b0);
        rst = 1'b0;

        // WIDTH=1 exhaustive, back to back.
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            op1(abc[2], abc[1], abc[0], so_tab[i], co_tab[i]);
        end
        // WIDTH=1 half-adder path.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            op1(ab[1], ab[0], 1'b0, ha_so[i], ha_co[i]);
        end
        v1 = 1'b0;

        // WIDTH=8 boundaries.
        op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        v8 = 1'b0;
        repeat (2) @(negedge clk);

        // Hold: idle inputs driven to X must not disturb so/co.
        op8(8'd3, 8'd4, 1'b0, 8'd7, 1'b0);
        v8 = 1'b0; a8 = 'x; b8 = 'x; c8 = 1'bx;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold so", so8, 8'd7);
            chk("hold co", co8, 1'b0);
            chk("hold out_valid", ov8, 1'b0);
        end

        // Reset together with a valid operand set: the set is dropped.
        rst = 1'b1; v8 = 1'b1; a8 = 8'd5; b8 = 8'd6; c8 = 1'b0;
        @(negedge clk);
        rst = 1'b0; v8 = 1'b0;
        chk("rst+valid so", so8, 8'h00);
        chk("rst+valid co", co8, 1'b0);
        chk("rst+valid out_valid", ov8, 1'b0);
        @(negedge clk);
        chk("post-rst idle out_valid", ov8, 1'b0);

        // First op after reset, then four back-to-back ops.
        op8(8'd10, 8'd20, 1'b0, 8'd30, 1'b0);
        op8(8'd1, 8'd1, 1'b0, 8'd2, 1'b0);
        op8(8'd200, 8'd100, 1'b0, 8'd44, 1'b1);
        op8(8'd127, 8'd1, 1'b1, 8'd129, 1'b0);
        op8(8'd0, 8'd0, 1'b1, 8'd1, 1'b0);
        v8 = 1'b0;

        repeat (4) @(negedge clk);
        chk("w1 results drained", 64'(q1.size()), 64'd0);
        chk("w8 results drained", 64'(q8.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_full_adder
